// File: rtl/userio_osd_cmd_pkg.sv
// Shared opcodes, status tag and FSM encoding for the OSD command decoder.
package userio_osd_cmd_pkg;

  localparam logic [7:0] CMD_WRBUF  = 8'h20;
  localparam logic [7:0] CMD_WRCTRL = 8'h40;
  localparam logic [7:0] CMD_RDSTAT = 8'h80;
  localparam logic [3:0] STAT_TAG   = 4'hA;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_BUF  = 3'd1,
    S_WR_CTRL = 3'd2,
    S_RD_STAT = 3'd3,
    S_DISCARD = 3'd4
  } osd_state_t;

  // Any opcode outside the three known groups lands in DISCARD.
  function automatic osd_state_t decode_cmd(input logic [7:0] op);
    if (op[7:3] == CMD_WRBUF[7:3]) return S_WR_BUF;
    else if (op == CMD_WRCTRL)     return S_WR_CTRL;
    else if (op == CMD_RDSTAT)     return S_RD_STAT;
    else                           return S_DISCARD;
  endfunction

endpackage

// File: rtl/userio_osd_cmd.sv
// SPI command decoder for the OSD: buffer writes, control register load, status read.
module userio_osd_cmd
  import userio_osd_cmd_pkg::*;
#(
  parameter int BUF_AW = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk7_en,
  input  logic              vld,
  input  logic              rx,
  input  logic              cmd,
  input  logic [7:0]        din,
  output logic [7:0]        spi_in,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [7:0]        buf_data,
  output logic              buf_we,
  output logic [7:0]        osd_ctrl,
  output logic              busy
);

  osd_state_t        state, state_nxt;
  logic [BUF_AW-1:0] ptr;
  logic [2:0]        last_row;
  logic              is_cmd, is_data;
  logic [7:0]        status;

  assign is_cmd  = rx & cmd;
  assign is_data = rx & ~cmd;
  assign status  = {STAT_TAG, osd_ctrl[0], last_row};
  assign busy    = (state != S_IDLE);

  // Deselect wins over everything; a command restarts from any state.
  always_comb begin
    state_nxt = state;
    if (!vld)
      state_nxt = S_IDLE;
    else if (is_cmd)
      state_nxt = decode_cmd(din);
    else if (is_data && state == S_WR_CTRL)
      state_nxt = S_DISCARD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      last_row <= '0;
      osd_ctrl <= 8'h00;
      spi_in   <= 8'h00;
      buf_we   <= 1'b0;
      buf_addr <= '0;
      buf_data <= 8'h00;
    end else if (clk7_en) begin
      state  <= state_nxt;
      buf_we <= 1'b0;

      if (vld && is_data && state == S_WR_BUF) begin
        buf_we   <= 1'b1;
        buf_addr <= ptr;
        buf_data <= din;
        ptr      <= ptr + BUF_AW'(1);
      end

      if (vld && is_cmd && state_nxt == S_WR_BUF) begin
        ptr      <= BUF_AW'({din[2:0], 8'h00});
        last_row <= din[2:0];
      end

      if (vld && is_data && state == S_WR_CTRL)
        osd_ctrl <= din;

      // Status is snapshotted when the read command decodes and held after.
      if (vld && is_cmd && state_nxt == S_RD_STAT)
        spi_in <= status;
      else if (state_nxt != S_RD_STAT)
        spi_in <= 8'h00;
    end
  end

endmodule

// File: tb/tb_userio_osd_cmd.sv
// Self-checking bench for userio_osd_cmd: directed scenarios plus randomized traffic vs a model.
module tb_userio_osd_cmd;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk7_en = 1'b1;
  logic        vld = 1'b0;
  logic        rx = 1'b0;
  logic        cmd = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  spi_in;
  logic [10:0] buf_addr;
  logic [7:0]  buf_data;
  logic        buf_we;
  logic [7:0]  osd_ctrl;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 idle, 1 buffer write, 2 ctrl write, 3 status read, 4 discard.
  int m_mode, m_ptr, m_row, m_ctrl, m_we, m_addr, m_data, m_spi;

  userio_osd_cmd #(.BUF_AW(11)) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .vld(vld), .rx(rx), .cmd(cmd),
    .din(din), .spi_in(spi_in), .buf_addr(buf_addr), .buf_data(buf_data),
    .buf_we(buf_we), .osd_ctrl(osd_ctrl), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) clk7_en = ($urandom_range(3) != 0);

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_row = 0; m_ctrl = 0;
    m_we = 0; m_addr = 0; m_data = 0; m_spi = 0;
  endtask

  task automatic model_step(input logic v, input logic r, input logic c, input int d);
    m_we = 0;
    if (!v) begin
      m_mode = 0;
    end else if (r && c) begin
      if (d >= 8'h20 && d <= 8'h27) begin
        m_mode = 1; m_row = d % 8; m_ptr = m_row * 256;
      end else if (d == 8'h40) m_mode = 2;
      else if (d == 8'h80) begin
        m_mode = 3;
        m_spi = 8'hA0 + (m_ctrl % 2) * 8 + m_row;
      end else m_mode = 4;
    end else if (r) begin
      if (m_mode == 1) begin
        m_we = 1; m_addr = m_ptr; m_data = d; m_ptr = (m_ptr + 1) % 2048;
      end else if (m_mode == 2) begin
        m_ctrl = d; m_mode = 4;
      end
    end
    if (m_mode != 3) m_spi = 0;
  endtask

  // Present one byte event for exactly one enabled clock edge, then sample just after it.
  task automatic tick(input logic v, input logic r, input logic c, input logic [7:0] d);
    vld = v; rx = r; cmd = c; din = d;
    do @(posedge clk); while (clk7_en !== 1'b1);
    #1;
    rx = 1'b0;
    model_step(v, r, c, int'(d));
  endtask

  task automatic do_reset();
    rx = 1'b0; cmd = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    vld = 1'b1;
    do_reset();
    n_checks++;
    if ({spi_in, buf_addr, buf_data, buf_we, osd_ctrl, busy} !== 38'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: spi=%h addr=%h data=%h we=%b ctrl=%h busy=%b, want all zero",
               spi_in, buf_addr, buf_data, buf_we, osd_ctrl, busy);
    end
  endtask

  task automatic test_wrbuf();
    logic [7:0] bytes [3];
    bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC;
    do_reset();
    tick(1, 1, 1, 8'h23);
    n_checks++;
    if (busy !== 1'b1 || buf_we !== 1'b0) begin
      n_errors++; $display("FAIL wrbuf_decode: busy=%b we=%b, want 1/0", busy, buf_we);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, bytes[i]);
      n_checks++;
      if (buf_we !== 1'b1 || buf_addr !== 11'(12'h300 + i) || buf_data !== bytes[i]) begin
        n_errors++;
        $display("FAIL wrbuf_write%0d: we=%b addr=%h data=%h, want 1 %h %h",
                 i, buf_we, buf_addr, buf_data, 12'h300 + i, bytes[i]);
      end
    end
    tick(1, 0, 0, 8'h00);
    n_checks++;
    if (buf_we !== 1'b0) begin
      n_errors++; $display("FAIL wrbuf_pulse: we=%b after idle cycle, want 0", buf_we);
    end
  endtask

  task automatic test_wrap();
    int exp_addr;
    logic [7:0] d;
    tick(1, 1, 1, 8'h27);
    for (int i = 0; i < 257; i++) begin
      d = 8'($urandom);
      tick(1, 1, 0, d);
      exp_addr = (12'h700 + i) % 2048;
      n_checks++;
      if (buf_we !== 1'b1 || int'(buf_addr) != exp_addr || buf_data !== d) begin
        n_errors++;
        $display("FAIL wrap_write%0d: we=%b addr=%h data=%h, want 1 %h %h",
                 i, buf_we, buf_addr, buf_data, exp_addr, d);
      end
    end
    n_checks++;
    if (buf_addr !== 11'h000) begin
      n_errors++; $display("FAIL wrap_last: addr=%h, want 000", buf_addr);
    end
  endtask

  task automatic test_wrctrl();
    tick(1, 1, 1, 8'h40);
    tick(1, 1, 0, 8'h01);
    n_checks++;
    if (osd_ctrl !== 8'h01) begin
      n_errors++; $display("FAIL wrctrl_load: ctrl=%h, want 01", osd_ctrl);
    end
    tick(1, 1, 0, 8'hFF);
    n_checks++;
    if (osd_ctrl !== 8'h01 || buf_we !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL wrctrl_discard: ctrl=%h we=%b busy=%b, want 01 0 1", osd_ctrl, buf_we, busy);
    end
  endtask

  task automatic test_rdstat();
    int we_seen = 0;
    tick(1, 1, 1, 8'h25);
    if (buf_we) we_seen++;
    tick(0, 0, 0, 8'h00);
    if (buf_we) we_seen++;
    n_checks++;
    if (busy !== 1'b0 || spi_in !== 8'h00) begin
      n_errors++; $display("FAIL rdstat_deselect: busy=%b spi=%h, want 0 00", busy, spi_in);
    end
    tick(1, 1, 1, 8'h80);
    if (buf_we) we_seen++;
    n_checks++;
    if (spi_in !== 8'hAD) begin
      n_errors++; $display("FAIL rdstat_status: spi=%h, want AD", spi_in);
    end
    tick(1, 1, 0, 8'h5A);
    if (buf_we) we_seen++;
    n_checks++;
    if (spi_in !== 8'hAD || we_seen != 0) begin
      n_errors++;
      $display("FAIL rdstat_hold: spi=%h we_count=%0d, want AD 0", spi_in, we_seen);
    end
    tick(1, 1, 1, 8'h13);
    n_checks++;
    if (spi_in !== 8'h00 || busy !== 1'b1) begin
      n_errors++; $display("FAIL rdstat_leave: spi=%h busy=%b, want 00 1", spi_in, busy);
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 1, 1, 8'h21);
    tick(1, 1, 0, 8'h11);
    tick(1, 1, 0, 8'h22);
    do_reset();
    tick(1, 1, 0, 8'h33);
    n_checks++;
    if (buf_we !== 1'b0 || osd_ctrl !== 8'h00 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid: we=%b ctrl=%h busy=%b, want 0 00 0", buf_we, osd_ctrl, busy);
    end
  endtask

  task automatic test_back_to_back();
    tick(1, 1, 1, 8'h22);
    tick(1, 1, 0, 8'h77);
    n_checks++;
    if (buf_we !== 1'b1 || buf_addr !== 11'h200 || buf_data !== 8'h77) begin
      n_errors++;
      $display("FAIL b2b_write: we=%b addr=%h data=%h, want 1 200 77", buf_we, buf_addr, buf_data);
    end
    tick(1, 1, 1, 8'h40);
    n_checks++;
    if (buf_we !== 1'b0 || buf_addr !== 11'h200) begin
      n_errors++; $display("FAIL b2b_cmd: we=%b addr=%h, want 0 200", buf_we, buf_addr);
    end
    tick(1, 1, 0, 8'h7E);
    n_checks++;
    if (osd_ctrl !== 8'h7E || buf_we !== 1'b0) begin
      n_errors++; $display("FAIL b2b_ctrl: ctrl=%h we=%b, want 7E 0", osd_ctrl, buf_we);
    end
  endtask

  task automatic test_random();
    logic v, r, c;
    logic [7:0] d;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(15) != 0);
      r = ($urandom_range(2) != 0);
      c = ($urandom_range(4) == 0);
      case ($urandom_range(4))
        0: d = 8'h20 + 8'($urandom_range(7));
        1: d = 8'h40;
        2: d = 8'h80;
        default: d = 8'($urandom);
      endcase
      tick(v, r, c, d);
      n_checks++;
      if (int'(buf_we) != m_we || int'(spi_in) != m_spi || int'(osd_ctrl) != m_ctrl ||
          int'(busy) != (m_mode != 0) || int'(buf_addr) != m_addr || int'(buf_data) != m_data) begin
        n_errors++;
        $display("FAIL random%0d: we=%b spi=%h ctrl=%h busy=%b addr=%h data=%h, want %0d %h %h %0d %h %h",
                 i, buf_we, spi_in, osd_ctrl, busy, buf_addr, buf_data,
                 m_we, m_spi, m_ctrl, (m_mode != 0), m_addr, m_data);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wrbuf();
    test_wrap();
    test_wrctrl();
    test_rdstat();
    test_reset_mid();
    test_back_to_back();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/userio_osd_cmd.md
USERIO_OSD_CMD -- requirements
Module: userio_osd_cmd

Interface
REQ-001 Parameter: BUF_AW, 11, OSD buffer address width; row field is BUF_AW-8 bits, 3 at default.
REQ-002 clk  input  1  pixel clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 clk7_en  input  1  clock enable; all state updates occur only when high.
REQ-005 vld  input  1  SPI chip-select active, already synchronised to clk.
REQ-006 rx  input  1  one-clk7_en-cycle pulse: a byte was received.
REQ-007 cmd  input  1  qualifies rx: the received byte is the first byte after select.
REQ-008 din  input  8  received byte, stable while rx is high.
REQ-009 spi_in  output  8  byte the SPI slave shifts out next.
REQ-010 buf_addr  output  BUF_AW  OSD buffer write address.
REQ-011 buf_data  output  8  OSD buffer write data.
REQ-012 buf_we  output  1  OSD buffer write strobe, one clk7_en cycle.
REQ-013 osd_ctrl  output  8  OSD control register; bit0 = OSD enable.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 FSM states SHALL be: IDLE, WR_BUF, WR_CTRL, RD_STAT, DISCARD.
REQ-016 When rx=1 and cmd=1 in any state, the command SHALL be decoded from din:
- 0x20-0x27 -> WR_BUF, address pointer = {din[2:0],8'h00}, last_row = din[2:0].
- 0x40 -> WR_CTRL.
- 0x80 -> RD_STAT.
- any other value -> DISCARD.
REQ-017 In WR_BUF, each rx with cmd=0 SHALL drive buf_we=1, buf_data=din and buf_addr=pointer on the next clk7_en cycle, then increment the pointer by 1.
REQ-018 The pointer SHALL wrap from 2^BUF_AW-1 to 0, with no error and no stall.
REQ-019 In WR_CTRL, the first data byte SHALL load osd_ctrl; the FSM SHALL then go to DISCARD.
REQ-020 On entry to RD_STAT, spi_in SHALL equal status {4'hA, osd_ctrl[0], last_row[2:0]}; the value is registered on the clk7_en cycle that decodes the command.
REQ-021 Data bytes received in RD_STAT SHALL be ignored; spi_in SHALL hold the status value.
REQ-022 In all other states, spi_in SHALL be 8'h00.
REQ-023 In DISCARD, data bytes SHALL be ignored until the next command or until deselect.
REQ-024 vld=0 on a clk7_en cycle SHALL force IDLE and clear buf_we; this overrides a simultaneous rx.
REQ-025 rx with cmd=0 while in IDLE SHALL be ignored.
REQ-026 rx and cmd arriving together while a write is pending SHALL complete the pending write first, then decode the new command.
REQ-027 Latency from rx to buf_we SHALL be exactly one clk7_en cycle.
REQ-028 buf_we SHALL never stay high for more than one clk7_en cycle.

Reset
REQ-029 On reset, outputs SHALL take these values:
- state = IDLE
- osd_ctrl = 8'h00
- spi_in = 8'h00
- buf_we = 0
- buf_addr = 0
- buf_data = 0
- last_row = 0
- busy = 0
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer.
REQ-031 After reset, data bytes SHALL be ignored until the next rx with cmd=1.

Structure
REQ-032 A shared package SHALL hold:
- command opcodes: CMD_WRBUF = 8'h20, CMD_WRCTRL = 8'h40, CMD_RDSTAT = 8'h80
- status tag 4'hA
- the FSM state encoding
REQ-033 The block SHALL contain no sub-modules; the address pointer is an inline counter.

Verification
REQ-034 Send 0x23, then AA, BB, CC -> buf_we three times, at addr 0x300/0x301/0x302 with data AA/BB/CC.
REQ-035 Send 0x27, then 257 bytes -> last write at addr 0x000 (wrap from 0x7FF).
REQ-036 Send 0x40, then 0x01, then 0xFF -> osd_ctrl=0x01; the 0xFF is discarded.
REQ-037 Send 0x25, deselect, send 0x80 -> spi_in=0xAD; buf_we never asserted.
REQ-038 Assert reset after 0x21 and two data bytes, then send one data byte without cmd -> no buf_we; osd_ctrl=0x00.
